poi_window_seq: RTL and testbench
=================================

Name: poi_window_seq

Overview:
- Self-sequencing window/POI address generator for the mosaic-stitching datapath; parametrised successor of the single-step window/POI address stepper.
- Owns its own counters: one start launches a full scan of every POI and every window row under it, no external feedback of next-state values.
- Emits one ROI read address and one POI-table address per accepted beat on a valid/ready stream toward the ROI/POI memories and correlator.
- Adds configurable POI stride, selectable scan order, out-of-bounds flagging, backpressure, abort and done signalling.

Parameters:
- ROI_ROWS, 64, ROI image height in pixels.
- ROI_COLS, 64, ROI image width in pixels; row pitch of the ROI address.
- POI_ROWS, 16, POI grid rows.
- POI_COLS, 16, POI grid columns.
- WIN_ROWS, 32, window rows scanned per POI.
- POI_STRIDE, 1, pixel spacing between adjacent POIs, both axes.
- ROI_AW, $clog2(ROI_ROWS*ROI_COLS), ROI address width.
- POI_AW, $clog2(POI_ROWS*POI_COLS), POI address width.
- WR_W, $clog2(WIN_ROWS), window-row counter width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  launch scan; sampled only in IDLE.
- mode  in  1  latched at start: 0 = POI row inner (column-major), 1 = POI column inner (row-major).
- abort  in  1  terminate scan, return to IDLE.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the last beat is accepted.
- out_valid  out  1  beat valid.
- out_ready  in  1  consumer accepts beat.
- out_w_row  out  WR_W  window row of current beat.
- out_poi_row  out  $clog2(POI_ROWS)  POI row.
- out_poi_col  out  $clog2(POI_COLS)  POI column.
- out_w_addr  out  ROI_AW  ROI read address.
- out_poi_addr  out  POI_AW  POI table address.
- out_oob  out  1  window row falls outside the ROI.
- out_poi_last  out  1  current beat is the last window row of its POI.

Behaviour:
- Reset: state IDLE. All outputs 0: busy, done, out_valid, all counters/addresses, out_oob, out_poi_last. Reset has priority over abort and start.
- FSM states: IDLE, RUN, DONE.
- IDLE -> RUN: start=1. Latch mode, zero all counters. Next cycle out_valid=1, presenting tuple (0,0,0). Latency from start to first beat is 1 cycle.
- RUN, transfer: a transfer is out_valid & out_ready.
  - On transfer, counters advance and the new tuple appears the next cycle. Throughput is 1 beat/cycle.
  - With no transfer, all out_* signals hold stable.
- Counter order:
  - w_row is always innermost; it wraps WIN_ROWS-1 -> 0 and carries.
  - mode=0: carry steps poi_row; poi_row wrap at POI_ROWS-1 steps poi_col.
  - mode=1: carry steps poi_col; poi_col wrap at POI_COLS-1 steps poi_row.
- RUN -> DONE: transfer of the final beat (w_row=WIN_ROWS-1, poi_row=POI_ROWS-1, poi_col=POI_COLS-1). out_valid drops the next cycle.
- DONE: done=1 for exactly one cycle, then IDLE. Total beats per scan = POI_ROWS*POI_COLS*WIN_ROWS (8192 at defaults).
- Abort: abort=1 in RUN or DONE -> IDLE next cycle. out_valid=0, no done pulse, counters zeroed.
- start ignored outside IDLE. start and abort together in IDLE: stay IDLE.
- Address arithmetic (widened internally, no truncation before compare):
  - r = poi_row*POI_STRIDE + w_row
  - c = poi_col*POI_STRIDE
  - out_w_addr = r*ROI_COLS + c
  - out_poi_addr = poi_row*POI_COLS + poi_col
- OOB: out_oob=1 if r >= ROI_ROWS or c >= ROI_COLS; out_w_addr is then forced to 0. OOB beats are still emitted.
- Output timing: all out_* signals are registered; addresses are computed from the next counter values and registered with the counters on the same edge.
- out_poi_last = (out_w_row == WIN_ROWS-1).

Test Plan:
- Defaults, mode=0, out_ready=1, pulse start -> beat 0: addr 0/poi_addr 0; beat 31: w_row 31, w_addr 1984, poi_last=1; beat 32: poi_row 1, w_addr 64, poi_addr 16; exactly 8192 beats; final w_addr 2959, poi_addr 255; done one cycle later, busy low.
- mode=1, defaults -> beat 32: poi_col 1, poi_row 0, w_addr 1, poi_addr 1; beat 512: poi_row 1, poi_col 0, poi_addr 16.
- out_ready low for 5 cycles at beat 10 -> all out_* stable (w_row 10, w_addr 640), no beat skipped or duplicated; beat 11 follows on re-assertion.
- POI_STRIDE=3 override -> POI (15,0), w_row 18: r=63, out_oob=0, w_addr 4032; w_row 19: out_oob=1, w_addr 0.
- abort at beat 100 -> out_valid=0 and busy=0 next cycle, no done; a new start restarts at tuple (0,0,0).
- reset asserted mid-RUN -> all outputs 0 next cycle; start during RUN has no effect on the sequence.

Source files
------------

// File: rtl/poi_window_seq.sv
// poi_window_seq: self-sequencing window/POI address generator with valid/ready output,
// configurable stride, selectable scan order, OOB flagging, abort and done signalling.
module poi_window_seq #(
    parameter int ROI_ROWS   = 64,
    parameter int ROI_COLS   = 64,
    parameter int POI_ROWS   = 16,
    parameter int POI_COLS   = 16,
    parameter int WIN_ROWS   = 32,
    parameter int POI_STRIDE = 1,
    parameter int ROI_AW     = $clog2(ROI_ROWS*ROI_COLS),
    parameter int POI_AW     = $clog2(POI_ROWS*POI_COLS),
    parameter int WR_W       = $clog2(WIN_ROWS),
    parameter int PR_W       = $clog2(POI_ROWS),
    parameter int PC_W       = $clog2(POI_COLS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              mode,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WR_W-1:0]   out_w_row,
    output logic [PR_W-1:0]   out_poi_row,
    output logic [PC_W-1:0]   out_poi_col,
    output logic [ROI_AW-1:0] out_w_addr,
    output logic [POI_AW-1:0] out_poi_addr,
    output logic              out_oob,
    output logic              out_poi_last
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic              r_mode;
    logic [WR_W-1:0]   r_w_row;
    logic [PR_W-1:0]   r_poi_row;
    logic [PC_W-1:0]   r_poi_col;
    logic [ROI_AW-1:0] r_w_addr;
    logic [POI_AW-1:0] r_poi_addr;
    logic              r_oob;
    logic              r_poi_last;

    logic              w_go, w_keep, w_step, w_final;
    logic              w_w_last, w_pr_last, w_pc_last, w_adv_pr, w_adv_pc;
    logic [WR_W-1:0]   w_n_w;
    logic [PR_W-1:0]   w_n_pr;
    logic [PC_W-1:0]   w_n_pc;
    logic [1:0]        w_n_state;
    logic [31:0]       w_r, w_c;
    logic              w_n_oob;

    always_comb begin
        w_go      = (r_state == S_IDLE) && start && !abort;
        w_keep    = (r_state == S_RUN) && !abort;
        w_step    = w_keep && out_ready;
        w_w_last  = r_w_row == WR_W'(WIN_ROWS-1);
        w_pr_last = r_poi_row == PR_W'(POI_ROWS-1);
        w_pc_last = r_poi_col == PC_W'(POI_COLS-1);
        w_final   = w_w_last && w_pr_last && w_pc_last;
        // mode 0 walks POI rows inside columns; mode 1 walks POI columns inside rows
        w_adv_pr  = r_mode ? (w_w_last && w_pc_last) : w_w_last;
        w_adv_pc  = r_mode ? w_w_last : (w_w_last && w_pr_last);
        w_n_w     = w_step ? (w_w_last ? '0 : r_w_row + WR_W'(1)) : w_keep ? r_w_row : '0;
        w_n_pr    = (w_step && w_adv_pr) ? (w_pr_last ? '0 : r_poi_row + PR_W'(1)) :
                    w_keep ? r_poi_row : '0;
        w_n_pc    = (w_step && w_adv_pc) ? (w_pc_last ? '0 : r_poi_col + PC_W'(1)) :
                    w_keep ? r_poi_col : '0;
        w_n_state = w_go ? S_RUN : (w_step && w_final) ? S_DONE : w_keep ? S_RUN : S_IDLE;
        w_r       = 32'(w_n_pr) * 32'(POI_STRIDE) + 32'(w_n_w);
        w_c       = 32'(w_n_pc) * 32'(POI_STRIDE);
        w_n_oob   = (w_r >= 32'(ROI_ROWS)) || (w_c >= 32'(ROI_COLS));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mode     <= 1'b0;
            r_w_row    <= '0;
            r_poi_row  <= '0;
            r_poi_col  <= '0;
            r_w_addr   <= '0;
            r_poi_addr <= '0;
            r_oob      <= 1'b0;
            r_poi_last <= 1'b0;
        end else begin
            r_state    <= w_n_state;
            r_mode     <= w_go ? mode : r_mode;
            r_w_row    <= w_n_w;
            r_poi_row  <= w_n_pr;
            r_poi_col  <= w_n_pc;
            r_w_addr   <= w_n_oob ? '0 : ROI_AW'(w_r * 32'(ROI_COLS) + w_c);
            r_poi_addr <= POI_AW'(32'(w_n_pr) * 32'(POI_COLS) + 32'(w_n_pc));
            r_oob      <= w_n_oob;
            r_poi_last <= w_n_w == WR_W'(WIN_ROWS-1);
        end
    end

    assign busy         = r_state == S_RUN;
    assign out_valid    = r_state == S_RUN;
    assign done         = r_state == S_DONE;
    assign out_w_row    = r_w_row;
    assign out_poi_row  = r_poi_row;
    assign out_poi_col  = r_poi_col;
    assign out_w_addr   = r_w_addr;
    assign out_poi_addr = r_poi_addr;
    assign out_oob      = r_oob;
    assign out_poi_last = r_poi_last;
endmodule

// File: tb/tb_poi_window_seq.sv
// tb_poi_window_seq: directed bench for poi_window_seq; a stride-1 and a stride-3 instance
// share all inputs and run in lockstep.
module tb_poi_window_seq;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, mode = 1'b0, abort = 1'b0, out_ready = 1'b1;
    logic a_busy, a_done, a_valid, a_oob, a_last;
    logic b_busy, b_done, b_valid, b_oob, b_last;
    logic [4:0]  a_w, b_w;
    logic [3:0]  a_pr, a_pc, b_pr, b_pc;
    logic [11:0] a_addr, b_addr;
    logic [7:0]  a_paddr, b_paddr;
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    poi_window_seq dut_a (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .busy(a_busy), .done(a_done), .out_valid(a_valid), .out_ready(out_ready),
        .out_w_row(a_w), .out_poi_row(a_pr), .out_poi_col(a_pc), .out_w_addr(a_addr),
        .out_poi_addr(a_paddr), .out_oob(a_oob), .out_poi_last(a_last)
    );

    poi_window_seq #(.POI_STRIDE(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .abort(abort),
        .busy(b_busy), .done(b_done), .out_valid(b_valid), .out_ready(out_ready),
        .out_w_row(b_w), .out_poi_row(b_pr), .out_poi_col(b_pc), .out_w_addr(b_addr),
        .out_poi_addr(b_paddr), .out_oob(b_oob), .out_poi_last(b_last)
    );

    // Expected {w_row, poi_row, poi_col, w_addr, poi_addr, oob, poi_last} of beat k
    function automatic logic [34:0] model(int k, bit m, int s);
        int w, pr, pc, r, c, a, p;
        bit oob;
        w = k % 32;
        pr = m ? k / 512 : (k / 32) % 16;
        pc = m ? (k / 32) % 16 : k / 512;
        r = pr * s + w;
        c = pc * s;
        oob = (r >= 64) || (c >= 64);
        a = oob ? 0 : r * 64 + c;
        p = pr * 16 + pc;
        return {w[4:0], pr[3:0], pc[3:0], a[11:0], p[7:0], oob, w == 31};
    endfunction

    function automatic logic [34:0] tup_a();
        return {a_w, a_pr, a_pc, a_addr, a_paddr, a_oob, a_last};
    endfunction

    function automatic logic [34:0] tup_b();
        return {b_w, b_pr, b_pc, b_addr, b_paddr, b_oob, b_last};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input bit m);
        mode = m;
        start = 1'b1;
        tick();
        start = 1'b0;
        mode = ~m;
    endtask

    task automatic finish_abort();
        abort = 1'b1;
        tick();
        abort = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if ({a_busy, a_done, a_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_ctrl got %b want 000", {a_busy, a_done, a_valid});
        end
        checks++;
        if (tup_a() !== 35'd0) begin
            failures++;
            $display("FAIL reset_outs got %h want 0", tup_a());
        end
        reset = 1'b0;
        tick();
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid got %b want 0", a_valid);
        end
    endtask

    task automatic test_scan_mode0();
        int k = 0, cyc = 0, bad = 0;
        out_ready = 1'b1;
        launch(1'b0);
        checks++;
        if (a_valid !== 1'b1) begin
            failures++;
            $display("FAIL first_beat_latency valid got %b want 1", a_valid);
        end
        while (k < 8192 && cyc < 9000) begin
            if (a_valid) begin
                if (tup_a() !== model(k, 1'b0, 1) || tup_b() !== model(k, 1'b0, 3)) bad++;
                if (k == 0 || k == 31 || k == 32 || k == 8191) begin
                    checks++;
                    if (tup_a() !== model(k, 1'b0, 1)) begin
                        failures++;
                        $display("FAIL m0_beat%0d got %h want %h", k, tup_a(), model(k, 1'b0, 1));
                    end
                end
                if (k == 31) begin
                    checks++;
                    if ({a_w, a_addr, a_last} !== {5'd31, 12'd1984, 1'b1}) begin
                        failures++;
                        $display("FAIL m0_beat31 w/addr/last got %0d/%0d/%b want 31/1984/1", a_w, a_addr, a_last);
                    end
                end
                if (k == 32) begin
                    checks++;
                    if ({a_pr, a_addr, a_paddr} !== {4'd1, 12'd64, 8'd16}) begin
                        failures++;
                        $display("FAIL m0_beat32 pr/addr/paddr got %0d/%0d/%0d want 1/64/16", a_pr, a_addr, a_paddr);
                    end
                end
                if (k == 8191) begin
                    checks++;
                    if ({a_addr, a_paddr} !== {12'd2959, 8'd255}) begin
                        failures++;
                        $display("FAIL m0_final addr/paddr got %0d/%0d want 2959/255", a_addr, a_paddr);
                    end
                end
                if (k == 498) begin
                    checks++;
                    if ({b_pr, b_pc, b_w, b_oob, b_addr} !== {4'd15, 4'd0, 5'd18, 1'b0, 12'd4032}) begin
                        failures++;
                        $display("FAIL s3_edge_in pr/pc/w/oob/addr got %0d/%0d/%0d/%b/%0d want 15/0/18/0/4032", b_pr, b_pc, b_w, b_oob, b_addr);
                    end
                end
                if (k == 499) begin
                    checks++;
                    if ({b_w, b_oob, b_addr} !== {5'd19, 1'b1, 12'd0}) begin
                        failures++;
                        $display("FAIL s3_edge_oob w/oob/addr got %0d/%b/%0d want 19/1/0", b_w, b_oob, b_addr);
                    end
                end
                k++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL m0_model_beats mismatched got %0d want 0", bad);
        end
        checks++;
        if (k !== 8192) begin
            failures++;
            $display("FAIL m0_beat_count got %0d want 8192", k);
        end
        checks++;
        if ({a_done, a_valid, a_busy} !== 3'b100) begin
            failures++;
            $display("FAIL m0_done done/valid/busy got %b want 100", {a_done, a_valid, a_busy});
        end
        tick();
        checks++;
        if ({a_done, a_valid, a_busy} !== 3'b000) begin
            failures++;
            $display("FAIL m0_done_pulse done/valid/busy got %b want 000", {a_done, a_valid, a_busy});
        end
    endtask

    task automatic test_scan_mode1();
        int k = 0, cyc = 0, bad = 0;
        launch(1'b1);
        while (k < 513 && cyc < 600) begin
            if (a_valid) begin
                if (tup_a() !== model(k, 1'b1, 1)) bad++;
                if (k == 32) begin
                    checks++;
                    if ({a_pc, a_pr, a_addr, a_paddr} !== {4'd1, 4'd0, 12'd1, 8'd1}) begin
                        failures++;
                        $display("FAIL m1_beat32 pc/pr/addr/paddr got %0d/%0d/%0d/%0d want 1/0/1/1", a_pc, a_pr, a_addr, a_paddr);
                    end
                end
                if (k == 512) begin
                    checks++;
                    if ({a_pr, a_pc, a_paddr} !== {4'd1, 4'd0, 8'd16}) begin
                        failures++;
                        $display("FAIL m1_beat512 pr/pc/paddr got %0d/%0d/%0d want 1/0/16", a_pr, a_pc, a_paddr);
                    end
                end
                k++;
            end
            tick();
            cyc++;
        end
        checks++;
        if (bad !== 0 || k !== 513) begin
            failures++;
            $display("FAIL m1_model_beats mismatched/count got %0d/%0d want 0/513", bad, k);
        end
        finish_abort();
    endtask

    task automatic test_backpressure();
        launch(1'b0);
        repeat (10) tick();
        checks++;
        if ({a_w, a_addr} !== {5'd10, 12'd640}) begin
            failures++;
            $display("FAIL bp_beat10 w/addr got %0d/%0d want 10/640", a_w, a_addr);
        end
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({a_valid, tup_a()} !== {1'b1, model(10, 1'b0, 1)}) begin
                failures++;
                $display("FAIL bp_hold%0d got %b/%h want 1/%h", i, a_valid, tup_a(), model(10, 1'b0, 1));
            end
        end
        out_ready = 1'b1;
        tick();
        checks++;
        if ({a_w, a_addr} !== {5'd11, 12'd704}) begin
            failures++;
            $display("FAIL bp_resume w/addr got %0d/%0d want 11/704", a_w, a_addr);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({a_valid, a_w} !== {1'b1, 5'd12}) begin
            failures++;
            $display("FAIL start_in_run valid/w got %b/%0d want 1/12", a_valid, a_w);
        end
        finish_abort();
    endtask

    task automatic test_abort();
        launch(1'b0);
        repeat (100) tick();
        checks++;
        if (a_addr !== 12'd448) begin
            failures++;
            $display("FAIL ab_beat100 addr got %0d want 448", a_addr);
        end
        finish_abort();
        checks++;
        if ({a_valid, a_busy, a_done, a_w, a_pr, a_addr} !== 24'd0) begin
            failures++;
            $display("FAIL ab_idle valid/busy/done/w/pr/addr got %b%b%b/%0d/%0d/%0d want 000/0/0/0", a_valid, a_busy, a_done, a_w, a_pr, a_addr);
        end
        tick();
        checks++;
        if (a_done !== 1'b0) begin
            failures++;
            $display("FAIL ab_no_done got %b want 0", a_done);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL start_with_abort valid got %b want 0", a_valid);
        end
        tick();
        start = 1'b0;
        checks++;
        if ({a_valid, tup_a()} !== {1'b1, model(0, 1'b0, 1)}) begin
            failures++;
            $display("FAIL ab_restart got %b/%h want 1/%h", a_valid, tup_a(), model(0, 1'b0, 1));
        end
        finish_abort();
    endtask

    task automatic test_reset_mid();
        launch(1'b0);
        repeat (40) tick();
        reset = 1'b1;
        tick();
        checks++;
        if ({a_busy, a_done, a_valid, tup_a()} !== 38'd0) begin
            failures++;
            $display("FAIL reset_mid got %b/%h want 000/0", {a_busy, a_done, a_valid}, tup_a());
        end
        reset = 1'b0;
        tick();
        checks++;
        if (a_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_idle valid got %b want 0", a_valid);
        end
    endtask

    initial begin
        test_reset();
        test_scan_mode0();
        test_scan_mode1();
        test_backpressure();
        test_abort();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
